// File: rtl/strided_window_reader_pkg.sv
// strided_window_reader_pkg: shape field positions, FSM encoding and window coordinate type
package strided_window_reader_pkg;
  localparam int C_MSB = 31;
  localparam int C_LSB = 20;
  localparam int H_MSB = 19;
  localparam int H_LSB = 10;
  localparam int W_MSB = 9;
  localparam int W_LSB = 0;
  localparam int COORD_W = 8;
  typedef enum logic [2:0] {IDLE, WAIT_SUF, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [COORD_W-1:0] c;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x0;
  } coord_t;
endpackage

// File: rtl/window_skid_fifo.sv
// window_skid_fifo: 2-entry FIFO holding assembled window beats (data, coord, last) ahead of the consumer
// Ports: clk, rstn (sync active-low); in_valid/in_ready/in_data write side; out_valid/out_ready/out_data
// read side (head entry); count is the current occupancy.
module window_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp, push, pop;
  assign in_ready = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_data = mem[rp];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= in_data;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/strided_window_reader.sv
// strided_window_reader: reads K_X-column sliding windows from N_BUF_X column-rotated banks and streams them out
// Ports: clk, rstn (sync active-low); shape/start/sufficient control a pass; rdaddr/buf_do drive and read
// the banks (1-cycle latency); win_data/win_valid/win_ready/win_coord/win_last carry window beats; busy, done.
// Optional: define STRIDED_WINDOW_PERF_EN to add stall_cycles (stalled-valid cycles in RUN/DRAIN).
module strided_window_reader
  import strided_window_reader_pkg::*;
#(
  parameter int N_BUF_X    = 5,
  parameter int K_X        = 3,
  parameter int B_BUF_ADDR = 9,
  parameter int B_SHAPE    = 32,
  parameter int B_COORD    = 8,
  parameter int DATA_WIDTH = 64,
  parameter int C_SHIFT    = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [B_SHAPE-1:0]             shape,
  input  logic                           start,
  input  logic                           sufficient,
  output logic [B_BUF_ADDR*N_BUF_X-1:0]  rdaddr,
  input  logic [DATA_WIDTH*N_BUF_X-1:0]  buf_do,
  output logic [DATA_WIDTH*K_X-1:0]      win_data,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [3*B_COORD-1:0]           win_coord,
  output logic                           win_last,
  output logic                           busy,
  output logic                           done
`ifdef STRIDED_WINDOW_PERF_EN
  ,
  output logic [31:0]                    stall_cycles
`endif
);
  localparam int XB = $clog2(N_BUF_X + 1);
  localparam int NW = C_MSB - C_LSB + 1;
  localparam int HW = H_MSB - H_LSB + 1;
  localparam int WW = W_MSB - W_LSB + 1;
  localparam int FW = DATA_WIDTH * K_X + 3 * B_COORD + 1;
  state_t state, state_n;
  logic [B_COORD-1:0] cc, yy, xx, nc_m1, h_m1, x_end;
  logic [B_BUF_ADDR-1:0] colw, off, x_base;
  logic [XB-1:0] x_bank, rd_rot;
  logic [NW-1:0] nc_f;
  logic [HW-1:0] h_f;
  logic [WW-1:0] w_f;
  logic empty_pass, rd_v, rd_last, issue, pop, c_end, y_end, is_last, f_valid, f_in_ready;
  logic [3*B_COORD-1:0] rd_coord;
  logic [1:0] f_cnt;
  logic [2:0] occ;
  logic [B_BUF_ADDR*N_BUF_X-1:0] rd_vec;
  logic [DATA_WIDTH*K_X-1:0] rot;
  assign nc_f = shape[C_MSB:C_LSB] >> C_SHIFT;
  assign h_f = shape[H_MSB:H_LSB];
  assign w_f = shape[W_MSB:W_LSB];
  assign pop = f_valid & win_ready;
  // occupancy once this cycle's pop and the in-flight read land; an issue needs it below 2
  assign occ = 3'(f_cnt) + 3'(rd_v) - 3'(pop);
  assign issue = state == RUN && occ < 3'd2;
  assign c_end = cc == nc_m1;
  assign y_end = yy == h_m1;
  assign is_last = c_end && y_end && xx == x_end;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign win_valid = f_valid;
  assign rdaddr = issue ? rd_vec : '0;
  // x_base = (x0/N)*COLW, x_bank = x0 mod N; a lane past bank N-1 wraps into the next column group
  always_comb begin
    rd_vec = '0;
    for (int k = 0; k < K_X; k++)
      rd_vec[((int'(x_bank) + k) % N_BUF_X) * B_BUF_ADDR +: B_BUF_ADDR] =
        x_base + off + ((int'(x_bank) + k >= N_BUF_X) ? colw : '0);
  end
  always_comb begin
    rot = '0;
    for (int k = 0; k < K_X; k++)
      rot[k * DATA_WIDTH +: DATA_WIDTH] = buf_do[((int'(rd_rot) + k) % N_BUF_X) * DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start ? WAIT_SUF : IDLE;
      WAIT_SUF: state_n = !sufficient ? WAIT_SUF : empty_pass ? DONE : RUN;
      RUN:      state_n = (issue && is_last) ? DRAIN : RUN;
      DRAIN:    state_n = occ == 3'd0 ? DONE : DRAIN;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cc <= '0;
      yy <= '0;
      xx <= '0;
      nc_m1 <= '0;
      h_m1 <= '0;
      x_end <= '0;
      colw <= '0;
      off <= '0;
      x_base <= '0;
      x_bank <= '0;
      empty_pass <= 1'b0;
      rd_v <= 1'b0;
      rd_rot <= '0;
      rd_coord <= '0;
      rd_last <= 1'b0;
    end else begin
      state <= state_n;
      rd_v <= issue;
      if (state == IDLE && start) begin
        nc_m1 <= B_COORD'(nc_f - NW'(1));
        h_m1 <= B_COORD'(h_f - HW'(1));
        x_end <= B_COORD'(w_f - WW'(K_X));
        colw <= B_BUF_ADDR'(h_f) * B_BUF_ADDR'(nc_f);
        empty_pass <= w_f < WW'(K_X) || nc_f == '0 || h_f == '0;
        cc <= '0;
        yy <= '0;
        xx <= '0;
        off <= '0;
        x_base <= '0;
        x_bank <= '0;
      end
      if (issue) begin
        rd_rot <= x_bank;
        rd_coord <= {cc, yy, xx};
        rd_last <= is_last;
        cc <= c_end ? '0 : cc + B_COORD'(1);
        off <= (c_end && y_end) ? '0 : off + B_BUF_ADDR'(1);
        if (c_end) yy <= y_end ? '0 : yy + B_COORD'(1);
        if (c_end && y_end) begin
          xx <= xx + B_COORD'(1);
          x_bank <= (x_bank == XB'(N_BUF_X - 1)) ? '0 : x_bank + XB'(1);
          x_base <= (x_bank == XB'(N_BUF_X - 1)) ? x_base + colw : x_base;
        end
      end
    end
  end
`ifdef STRIDED_WINDOW_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn || (state == IDLE && start)) stall_cycles <= '0;
    else if ((state == RUN || state == DRAIN) && win_valid && !win_ready && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif
  window_skid_fifo #(.W(FW)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (rd_v),
    .in_ready  (f_in_ready),
    .in_data   ({rot, rd_coord, rd_last}),
    .out_valid (f_valid),
    .out_ready (win_ready),
    .out_data  ({win_data, win_coord, win_last}),
    .count     (f_cnt)
  );
endmodule

// File: tb/tb_strided_window_reader.sv
// tb_strided_window_reader: directed scoreboard bench with a 1-cycle-latency bank model
module tb_strided_window_reader;
  import strided_window_reader_pkg::*;
  typedef struct packed {
    logic [191:0] d;
    coord_t       co;
    logic         l;
  } beat_t;
  localparam logic [44:0] HIT = 45'h0000_0804_0200;
  logic clk = 1'b0, rstn, start, sufficient, win_ready;
  logic [31:0] shape;
  logic [44:0] rdaddr;
  logic [319:0] buf_do;
  logic [191:0] win_data, pd;
  logic [23:0] win_coord;
  logic [24:0] pc;
  logic win_valid, win_last, busy, done, stalled = 1'b0, saw_last = 1'b0;
`ifdef STRIDED_WINDOW_PERF_EN
  logic [31:0] stall_cycles;
`endif
  beat_t sb[$];
  beat_t e;
  int total = 0, bad = 0, nbeats = 0, stalls = 0, hits = 0, cyc = 0, last_cyc = 0;
  strided_window_reader dut (
    .clk        (clk),
    .rstn       (rstn),
    .shape      (shape),
    .start      (start),
    .sufficient (sufficient),
    .rdaddr     (rdaddr),
    .buf_do     (buf_do),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_coord  (win_coord),
    .win_last   (win_last),
    .busy       (busy),
`ifdef STRIDED_WINDOW_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .done       (done)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] mk(input int b, input logic [8:0] a);
    return {24'hA5C3E1, 8'(b), 23'h0, a};
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 5; i++) buf_do[i*64 +: 64] <= mk(i, rdaddr[i*9 +: 9]);
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_pass(input int c, input int h, input int w);
    int nc = c >> 2;
    int colw = h * nc;
    beat_t b;
    for (int x0 = 0; x0 <= w - 3; x0++)
      for (int y = 0; y < h; y++)
        for (int ch = 0; ch < nc; ch++) begin
          for (int k = 0; k < 3; k++)
            b.d[k*64 +: 64] = mk((x0 + k) % 5, 9'(((x0 + k) / 5) * colw + y * nc + ch));
          b.co = {8'(ch), 8'(y), 8'(x0)};
          b.l = (ch == nc - 1) && (y == h - 1) && (x0 == w - 3);
          sb.push_back(b);
        end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (stalled) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_data", win_data, pd);
        chk("hold_coord_last", {win_coord, win_last}, pc);
      end
      if (win_valid && win_ready) begin
        chk("beat_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("beat_data", win_data, e.d);
          chk("beat_coord", win_coord, e.co);
          chk("beat_last", win_last, e.l);
          if (e.l) begin
            saw_last = 1'b1;
            last_cyc = cyc;
          end
        end
        nbeats++;
      end
      if (done && saw_last) begin
        chk("done_after_last", cyc - last_cyc, 1);
        saw_last = 1'b0;
      end
      if (rdaddr == HIT) hits++;
      if (busy && win_valid && !win_ready) stalls++;
    end
    stalled = rstn && win_valid && !win_ready;
    pd = win_data;
    pc = {win_coord, win_last};
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input int c, input int h, input int w);
    expect_pass(c, h, w);
    nbeats = 0;
    stalls = 0;
    hits = 0;
    shape = {12'(c), 10'(h), 10'(w)};
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic finish_pass(input string tag, input int n);
    int k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, done, 1);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done}, 0);
    chk({tag, "_beats"}, nbeats, n);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask
  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout");
  end
  initial begin
    int vcount, n, nb;
    rstn = 1'b0; start = 1'b0; shape = '0; sufficient = 1'b0; win_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdaddr", rdaddr, 0);
    chk("rst_data", {win_data, win_coord, win_last}, 0);
    tick();
    rstn = 1'b1;
    sufficient = 1'b1;
    win_ready = 1'b1;
    tick();
    launch(8, 2, 4);
    finish_pass("basic", 8);
    chk("basic_rdaddr_x0_1_c1", hits, 1);
    tick();
    launch(4, 1, 7);
    finish_pass("wrap", 5);
    tick();
    sufficient = 1'b0;
    launch(8, 2, 4);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (win_valid) vcount++;
    end
    chk("suf_wait_no_valid", vcount, 0);
    chk("suf_wait_busy", busy, 1);
    tick();
    sufficient = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!win_valid && n < 8);
    chk("suf_first_valid_latency", n <= 4, 1);
    finish_pass("suf", 8);
    tick();
    win_ready = 1'b0;
    launch(8, 4, 5);
    for (int i = 0; i < 16; i++) begin
      win_ready = i[0];
      tick();
    end
    win_ready = 1'b0;
    nb = nbeats;
    repeat (10) tick();
    chk("stall_no_beats", nbeats, nb);
    win_ready = 1'b1;
    finish_pass("toggle", 24);
`ifdef STRIDED_WINDOW_PERF_EN
    chk("stall_cycles", stall_cycles, stalls);
`endif
    tick();
    launch(8, 2, 2);
    finish_pass("narrow", 0);
    tick();
    launch(4, 1, 7);
    repeat (3) tick();
    shape = {12'd8, 10'd2, 10'd4};
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_pass("start_ignored", 5);
    repeat (3) @(negedge clk);
    chk("start_ignored_stays_idle", busy, 0);
    tick();
    win_ready = 1'b0;
    launch(8, 2, 4);
    repeat (6) tick();
    chk("pre_reset_valid", win_valid, 1);
    rstn = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_valid", win_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rdaddr", rdaddr, 0);
    chk("midrst_data", {win_data, win_coord, win_last}, 0);
    sb.delete();
    tick();
    rstn = 1'b1;
    win_ready = 1'b1;
    tick();
    launch(8, 2, 4);
    finish_pass("rerun", 8);
    chk("rerun_rdaddr_x0_1_c1", hits, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
